ysyx_25060170_ifu: RTL and testbench

//  Instruction fetch unit; producer side of the fetch->decode link (pc_o/inst_o into IDU).

---
 rtl/ysyx_25060170_ifu.sv | 124 ++++++++++++
 tb/tb_ysyx_25060170_ifu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_ifu.sv
// ysyx_25060170_ifu: instruction fetch unit (producer side of the fetch->decode link).
// Holds the PC, issues one imem read at a time and buffers the returned word for IDU.
// EXU redirects are accepted in any state and squash wrong-path fetches.
// Optional feature: define IFU_MISALIGN_CHECK_EN to trap misaligned redirect targets
// in a FAULT state with misalign_o raised; without it, redirect_pc[1:0] is ignored.
module ysyx_25060170_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        misalign_o
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic        drop;          // outstanding response belongs to a squashed fetch
  logic [31:0] redirect_tgt;
  logic        redirect_bad;

`ifdef IFU_MISALIGN_CHECK_EN
  assign redirect_tgt = redirect_pc;
  assign redirect_bad = (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign redirect_bad = 1'b0;
`endif

  // Request channel: only in FETCH, suppressed by a same-cycle redirect or reset.
  always_comb begin
    imem_req_valid = (state == FETCH) && !redirect_valid && !rst;
    imem_req_addr  = pc;
  end

  // Fetch state machine, PC and the decode-side output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      drop         <= 1'b0;
      inst_o       <= '0;
      pc_o         <= '0;
      inst_valid_o <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect_valid) begin
            pc    <= redirect_tgt;
            state <= redirect_bad ? FAULT : FETCH;
          end else if (imem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            // A response arriving with the redirect is discarded here; otherwise
            // the still-outstanding response is marked for dropping.
            pc   <= redirect_tgt;
            drop <= !imem_resp_valid;
            if (redirect_bad)         state <= FAULT;
            else if (imem_resp_valid) state <= FETCH;
          end else if (imem_resp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= FETCH;
            end else begin
              inst_o       <= imem_resp_data;
              pc_o         <= pc;
              inst_valid_o <= 1'b1;
              state        <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc           <= redirect_tgt;
            inst_valid_o <= 1'b0;
            state        <= redirect_bad ? FAULT : FETCH;
          end else if (inst_ready_i) begin
            pc           <= pc + PC_STEP;
            inst_valid_o <= 1'b0;
            state        <= FETCH;
          end
        end
        FAULT: begin
          if (imem_resp_valid) drop <= 1'b0;
          if (redirect_valid) begin
            pc <= redirect_tgt;
            // A squashed request may still be in flight; wait it out before refetching.
            if (!redirect_bad) state <= (drop && !imem_resp_valid) ? WAIT : FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  // Fault flag follows the alignment of the most recent redirect target.
  always_ff @(posedge clk) begin
    if (rst)                 misalign_o <= 1'b0;
    else if (redirect_valid) misalign_o <= redirect_bad;
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Testbench for ysyx_25060170_ifu: directed vector table, hand-written corner
// sequences and a randomized run checked against a transaction-level model.
module tb_ysyx_25060170_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        misalign_o;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  ysyx_25060170_ifu #(.RESET_PC(32'h8000_0000), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i), .pc_o(pc_o), .inst_o(inst_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    logic        redir;
    logic [31:0] rpc;
    logic        iready;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic resp, input logic [31:0] data,
                              input logic redir, input logic [31:0] rpc, input logic iready,
                              input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.rdy = rdy; v.resp = resp; v.data = data; v.redir = redir; v.rpc = rpc;
    v.iready = iready; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  // Memory contents seen by the random run: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic rv, input logic [31:0] addr,
                            input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                            input logic chkdata, input logic mis);
    chk({tag, " req_valid"}, {31'd0, imem_req_valid}, {31'd0, rv});
    if (rv) chk({tag, " req_addr"}, imem_req_addr, addr);
    chk({tag, " inst_valid"}, {31'd0, inst_valid_o}, {31'd0, iv});
    if (chkdata) begin
      chk({tag, " pc_o"}, pc_o, pc);
      chk({tag, " inst_o"}, inst_o, inst);
    end
    chk({tag, " misalign"}, {31'd0, misalign_o}, {31'd0, mis});
  endtask

  task automatic drive(input logic rdy, input logic resp, input logic [31:0] data,
                       input logic redir, input logic [31:0] rpc, input logic iready);
    imem_req_ready  = rdy;
    imem_resp_valid = resp;
    imem_resp_data  = data;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    inst_ready_i    = iready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[19];
  logic mac;

  // random-run reference model state
  logic [31:0] m_pc, m_addr;
  logic        m_held, m_pend, m_live, held_old, exp_rv, accept;
  int unsigned m_cnt, delivered;
  logic        r_rdy, r_resp, r_redir, r_iready;
  logic [31:0] r_data, r_rpc;

  initial begin
`ifdef IFU_MISALIGN_CHECK_EN
    mac = 1'b1;
`else
    mac = 1'b0;
`endif
    // rdy resp data          redir rpc           iready | rv addr          iv pc            inst
    tbl[0]  = mk(1, 0, 32'h0,          0, 32'h0,          0,  1, 32'h8000_0000, 0, 32'h0, 32'h0);
    tbl[1]  = mk(1, 1, 32'h0000_0413,  0, 32'h0,          0,  0, 32'h0,         0, 32'h0, 32'h0);
    tbl[2]  = mk(1, 0, 32'h0,          0, 32'h0,          1,  0, 32'h0,         1, 32'h8000_0000, 32'h0000_0413);
    tbl[3]  = mk(1, 0, 32'h0,          0, 32'h0,          0,  1, 32'h8000_0004, 0, 32'h0, 32'h0);
    tbl[4]  = mk(1, 1, 32'h0010_0093,  0, 32'h0,          0,  0, 32'h0,         0, 32'h0, 32'h0);
    tbl[5]  = mk(1, 0, 32'h0,          0, 32'h0,          1,  0, 32'h0,         1, 32'h8000_0004, 32'h0010_0093);
    tbl[6]  = mk(1, 0, 32'h0,          0, 32'h0,          0,  1, 32'h8000_0008, 0, 32'h0, 32'h0);
    tbl[7]  = mk(1, 1, 32'h0020_0113,  0, 32'h0,          0,  0, 32'h0,         0, 32'h0, 32'h0);
    tbl[8]  = mk(1, 0, 32'h0,          0, 32'h0,          1,  0, 32'h0,         1, 32'h8000_0008, 32'h0020_0113);
    tbl[9]  = mk(1, 0, 32'h0,          0, 32'h0,          0,  1, 32'h8000_000C, 0, 32'h0, 32'h0);
    tbl[10] = mk(1, 0, 32'h0,          1, 32'h8000_0100,  0,  0, 32'h0,         0, 32'h0, 32'h0);
    tbl[11] = mk(1, 0, 32'h0,          0, 32'h0,          0,  0, 32'h0,         0, 32'h0, 32'h0);
    tbl[12] = mk(1, 1, 32'hDEAD_BEEF,  0, 32'h0,          0,  0, 32'h0,         0, 32'h0, 32'h0);
    tbl[13] = mk(1, 0, 32'h0,          0, 32'h0,          0,  1, 32'h8000_0100, 0, 32'h0, 32'h0);
    tbl[14] = mk(1, 1, 32'h1111_1111,  0, 32'h0,          0,  0, 32'h0,         0, 32'h0, 32'h0);
    tbl[15] = mk(1, 0, 32'h0,          1, 32'h8000_0040,  1,  0, 32'h0,         1, 32'h8000_0100, 32'h1111_1111);
    tbl[16] = mk(1, 0, 32'h0,          0, 32'h0,          0,  1, 32'h8000_0040, 0, 32'h0, 32'h0);
    tbl[17] = mk(1, 1, 32'h2222_2222,  0, 32'h0,          0,  0, 32'h0,         0, 32'h0, 32'h0);
    tbl[18] = mk(1, 0, 32'h0,          0, 32'h0,          0,  0, 32'h0,         1, 32'h8000_0040, 32'h2222_2222);

    // Reset values
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    tick();
    @(negedge clk);
    expect_out("reset", 0, 32'h0, 0, 32'h0, 32'h0, 1, 0);
    tick();
    rst = 1'b0;

    // Directed table: first fetch latency, sequential cadence, squash in WAIT, redirect vs IDU accept
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rdy, tbl[i].resp, tbl[i].data, tbl[i].redir, tbl[i].rpc, tbl[i].iready);
      @(negedge clk);
      expect_out($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_iv,
                 tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_iv, 0);
      tick();
    end

    // IDU stalls 10 cycles in HOLD: outputs stable, no requests even with memory ready
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 32'h0, 0, 32'h0, 0);
      @(negedge clk);
      expect_out($sformatf("stall%0d", i), 0, 32'h0, 1, 32'h8000_0040, 32'h2222_2222, 1, 0);
      tick();
    end

    // PC wrap: redirect to 0xFFFFFFFC, fetch it, accept, next address is 0
    drive(1, 0, 32'h0, 1, 32'hFFFF_FFFC, 0);
    @(negedge clk); expect_out("wrap redir", 0, 32'h0, 1, 32'h8000_0040, 32'h2222_2222, 1, 0); tick();
    drive(1, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk); expect_out("wrap req", 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0, 0); tick();
    drive(1, 1, 32'hCAFE_0013, 0, 32'h0, 0);
    @(negedge clk); expect_out("wrap resp", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0); tick();
    drive(1, 0, 32'h0, 0, 32'h0, 1);
    @(negedge clk); expect_out("wrap hold", 0, 32'h0, 1, 32'hFFFF_FFFC, 32'hCAFE_0013, 1, 0); tick();
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk); expect_out("wrap next", 1, 32'h0000_0000, 0, 32'h0, 32'h0, 0, 0); tick();

    // Misaligned redirect
    drive(0, 0, 32'h0, 1, 32'h8000_0002, 0);
    @(negedge clk); expect_out("mis redir", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 0, 32'h0, 0);
      @(negedge clk);
      expect_out($sformatf("mis idle%0d", i), !mac, 32'h8000_0000, 0, 32'h0, 32'h0, 0, mac);
      tick();
    end
    drive(0, 0, 32'h0, 1, 32'h8000_0008, 0);
    @(negedge clk); expect_out("mis fix", 0, 32'h0, 0, 32'h0, 32'h0, 0, mac); tick();
    drive(1, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk); expect_out("mis refetch", 1, 32'h8000_0008, 0, 32'h0, 32'h0, 0, 0); tick();

    // Reset mid-operation (request outstanding)
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk); expect_out("midrst0", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0); tick();
    @(negedge clk); expect_out("midrst1", 0, 32'h0, 0, 32'h0, 32'h0, 1, 0); tick();
    rst = 1'b0;
    @(negedge clk); expect_out("midrst2", 1, 32'h8000_0000, 0, 32'h0, 32'h0, 0, 0); tick();

    // Randomized run against the transaction-level model
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    tick();
    rst = 1'b0;
    m_pc = 32'h8000_0000; m_addr = '0;
    m_held = 1'b0; m_pend = 1'b0; m_live = 1'b0; m_cnt = 0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      r_rdy  = ($urandom_range(0, 2) != 0);
      r_resp = 1'b0;
      r_data = '0;
      if (m_pend && m_cnt == 0) begin
        r_resp = 1'b1;
        r_data = mem_word(m_addr);
      end else if (!m_pend && $urandom_range(0, 7) == 0) begin
        r_resp = 1'b1;
        r_data = $urandom;
      end
      r_redir = ($urandom_range(0, 9) == 0);
      r_rpc   = $urandom;
      if (mac) r_rpc[1:0] = 2'b00;
      r_iready = ($urandom_range(0, 2) != 0);
      drive(r_rdy, r_resp, r_data, r_redir, r_rpc, r_iready);
      @(negedge clk);
      exp_rv = !m_held && !m_pend && !r_redir;
      expect_out("rand", exp_rv, m_pc, m_held, m_pc, mem_word(m_pc), m_held, 0);
      // advance the model across the coming clock edge
      accept   = exp_rv && r_rdy;
      held_old = m_held;
      if (r_redir) begin
        m_pc   = {r_rpc[31:2], 2'b00};
        m_held = 1'b0;
      end else if (held_old && r_iready) begin
        m_held = 1'b0;
        m_pc   = m_pc + 32'd4;
        delivered++;
      end
      if (m_pend && r_resp) begin
        m_pend = 1'b0;
        if (m_live && !r_redir) m_held = 1'b1;
      end else if (m_pend) begin
        m_cnt--;
      end
      if (r_redir) m_live = 1'b0;
      if (accept) begin
        m_pend = 1'b1;
        m_addr = m_pc;
        m_cnt  = $urandom_range(0, 2);
        m_live = 1'b1;
      end
      tick();
    end
    chk("rand progress", {31'd0, (delivered > 100)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
